seven_seg_scan_controller: RTL
==============================

// Module: seven_seg_scan_controller
// PURPOSE
//  Time-multiplexes a 4-digit common-anode 7-segment display from one clock.
//  Holds a 16-bit hex value (4 nibbles) and scans digits left to right.
//  Drives active-low anodes, cathodes and decimal point, with a blanking dead-time per slot to prevent ghosting.
//  Takes new values through a ready/valid load port. Updates apply only at frame boundaries, so the display never tears.
// PARAMETERS
//  CLK_DIV       100000  clock cycles per digit slot; must be > BLANK_CYCLES
//  BLANK_CYCLES  16      cycles at start of each slot with all anodes off; may be 0
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  enable      in   1   1 = scan, 0 = display dark
//  load_valid  in   1   request to load load_data/load_dp
//  load_data   in   16  [15:12] leftmost digit ... [3:0] rightmost digit
//  load_dp     in   4   decimal points, [3] leftmost; 1 = lit
//  load_ready  out  1   shadow register free; load accepted when valid&&ready
//  anode       out  4   active-low digit enables, [3] leftmost
//  cathode     out  7   active-low segments {g,f,e,d,c,b,a}
//  dp          out  1   active-low decimal point
//  digit_sel   out  2   index of digit being scanned (0 = leftmost)
//  frame_done  out  1   one-cycle pulse at end of each full 4-digit frame
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - anode=4'b1111, cathode=7'h7F, dp=1, digit_sel=0, frame_done=0, load_ready=1.
//   - Display and shadow registers = 0; pending=0; state IDLE; slot counter cnt=0.
//  States:
//   - IDLE: enable=0; anodes/cathodes/dp all off; cnt=0, digit=0.
//   - BLANK: cnt < BLANK_CYCLES.
//   - DRIVE: BLANK_CYCLES <= cnt <= CLK_DIV-1.
//   - IDLE->BLANK on the edge enable is sampled 1. BLANK->DRIVE when cnt reaches BLANK_CYCLES.
//   - At end of DRIVE (cnt=CLK_DIV-1): cnt->0, digit increments mod 4, back to BLANK.
//   - enable=0 in any state -> IDLE on the next edge (outputs dark, digit/cnt cleared).
//   - A new enable restarts at digit 0, cnt 0.
//  Outputs are registered: values reflect the state one edge earlier, so anode goes active 1 cycle after entering DRIVE.
//   - DRIVE, digit d: anode = 4'b0111,1011,1101,1110 for d=0..3; digit_sel=d.
//   - DRIVE: cathode = hexfont(nibble d); dp = ~dp_bit d.
//   - BLANK: anode=4'b1111 and cathode=7'h7F; digit_sel already shows the new digit.
//  Hex font (active-low):
//   - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//   - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
//  Load handshake: on valid&&ready, data/dp go to shadow, pending<=1, so load_ready=0 from the next cycle.
//   - valid while ready=0 is ignored; no stall, no error.
//  Frame swap happens on the edge with digit=3 and cnt=CLK_DIV-1:
//   - if pending, display<=shadow and pending<=0;
//   - frame_done=1 for exactly the following cycle;
//   - new values show from digit 0 of the next frame.
//  Simultaneous load at a swap edge while pending=0: data goes to shadow only, and the swap occurs at the end of the following frame.
//  Loads while enable=0 are accepted and swap immediately on the next edge (no frame running); frame_done is not pulsed.
//  cnt is $clog2(CLK_DIV) bits wide and wraps exactly at CLK_DIV-1; digit is 2 bits and wraps 3->0.
// TESTING (CLK_DIV=8, BLANK_CYCLES=2 unless noted)
//  1 Reset during DRIVE, digit 2 -> same instant: anode=1111, cathode=7F, dp=1, load_ready=1; after release with enable=1, scan restarts at digit 0.
//  2 Load 0x1234, dp=4'b0100, enable=1:
//    - per 8-cycle slot: 2 blank cycles, then anode 0111/cathode 79, 1011/24 with dp=0, 1101/30, 1110/19;
//    - frame_done every 32 cycles.
//  3 Showing 0x1234, load 0xABCD during digit 1:
//    - load_ready=0 next cycle; current frame still shows 1,2,3,4;
//    - swap edge -> load_ready=1; next frame shows 08,03,46,21.
//  4 Load asserted exactly on the swap edge with pending=0 -> next frame unchanged; the frame after shows new value.
//  5 enable 1->0 during DRIVE digit 1 -> next cycle anode=1111, cathode=7F; re-enable -> scan starts with digit 0 blank slot.
//  6 Back-to-back load_valid held high across 3 frames -> exactly one load accepted per frame; no handshake lost or duplicated.

Source files
------------

// File: rtl/seven_seg_scan_controller_if.sv
// Load port and display-drive signals of the 4-digit 7-segment scan controller.
// The master drives enable and the load request; the slave (controller) drives the display side.
interface seven_seg_scan_controller_if;
  logic        enable;
  logic        load_valid;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic        load_ready;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_done;

  modport master (
    output enable, load_valid, load_data, load_dp,
    input  load_ready, anode, cathode, dp, digit_sel, frame_done
  );

  modport slave (
    input  enable, load_valid, load_data, load_dp,
    output load_ready, anode, cathode, dp, digit_sel, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-slot blanking
// and a shadow register that is copied to the display only at frame boundaries.
module seven_seg_scan_controller #(
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic                          clk,
  input logic                          rst_n,
  seven_seg_scan_controller_if.slave   bus
);

  localparam int unsigned   CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam bit            NO_BLANK  = (BLANK_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;

  logic [15:0]   disp_q, disp_d;
  logic [3:0]    disp_dp_q, disp_dp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic          pending_q, pending_d;

  logic [3:0]    anode_q, anode_d;
  logic [6:0]    cathode_q, cathode_d;
  logic          dp_q, dp_d;
  logic [1:0]    digit_sel_q, digit_sel_d;
  logic          frame_done_q, frame_done_d;

  logic          slot_end;
  logic          frame_end;
  logic          accept;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h40;
      4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;
      4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;
      4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;
      4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;
      4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;
      4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;
      4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;
      default: hex_font = 7'h0E;
    endcase
  endfunction

  assign slot_end  = (state_q == DRIVE) && (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (digit_q == 2'd3) && bus.enable;
  assign accept    = bus.load_valid && !pending_q;

  // Scan sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      digit_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          digit_d = '0;
          state_d = NO_BLANK ? DRIVE : BLANK;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_BLANK) state_d = DRIVE;
        end
        DRIVE: begin
          if (slot_end) begin
            cnt_d   = '0;
            digit_d = digit_q + 1'b1;
            state_d = NO_BLANK ? DRIVE : BLANK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Accept and swap are mutually exclusive: accept needs pending=0, swap needs pending=1.
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;
    if (pending_q && (frame_end || state_q == IDLE)) begin
      disp_d    = shadow_q;
      disp_dp_d = shadow_dp_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d    = bus.load_data;
      shadow_dp_d = bus.load_dp;
      pending_d   = 1'b1;
    end
  end

  always_comb begin
    case (digit_q)
      2'd0:    nibble = disp_q[15:12];
      2'd1:    nibble = disp_q[11:8];
      2'd2:    nibble = disp_q[7:4];
      default: nibble = disp_q[3:0];
    endcase
  end

  // Registered drive reflects the sequencer state before the edge; disabling darkens at once.
  always_comb begin
    anode_d      = '1;
    cathode_d    = '1;
    dp_d         = 1'b1;
    digit_sel_d  = digit_q;
    frame_done_d = frame_end;
    if (!bus.enable) begin
      digit_sel_d = '0;
    end else if (state_q == DRIVE) begin
      anode_d   = ~(4'b1000 >> digit_q);
      cathode_d = hex_font(nibble);
      dp_d      = ~disp_dp_q[2'd3 - digit_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      digit_q      <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      anode_q      <= '1;
      cathode_q    <= '1;
      dp_q         <= 1'b1;
      digit_sel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      dp_q         <= dp_d;
      digit_sel_q  <= digit_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.load_ready = ~pending_q;
  assign bus.anode      = anode_q;
  assign bus.cathode    = cathode_q;
  assign bus.dp         = dp_q;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.frame_done = frame_done_q;

endmodule
